// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Frames a start / WIDTH data / stop bitstream sampled on bit_en strobes,
// assembles each good frame into a parallel word and offers it downstream
// with a valid/ready handshake. Bad stop bits raise frame_err, and good
// frames arriving while the holding register is full raise overrun.
// Optional feature: define PARITY_CHECK_EN to add an even-parity bit
// between the data bits and the stop bit.
module serial_word_receiver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             bit_en,
    output logic [0:WIDTH-1] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [0:WIDTH-1] buffer_q;
    logic             good_frame;
    logic             bad_frame;
    logic             parity_ok;
    logic             hold_free;

    // The holding register can take a new word if empty or emptied this edge.
    assign hold_free = !data_valid || data_ready;
    assign busy      = (state_q != IDLE);

`ifdef PARITY_CHECK_EN
    logic par_q;

    // Running XOR of data and parity bits; zero at stop time means even parity.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (bit_en) begin
            if (state_q == IDLE && !ser_in) begin
                par_q <= 1'b0;
            end else if (state_q == DATA || state_q == PARITY) begin
                par_q <= par_q ^ ser_in;
            end
        end
    end

    assign parity_ok = !par_q;
`else
    assign parity_ok = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge Clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and frame verdict at stop-bit time.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_en && !ser_in) state_d = DATA;
            end
            DATA: begin
                if (bit_en && cnt_q == LAST) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (bit_en) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                    if (ser_in && parity_ok) good_frame = 1'b1;
                    else                     bad_frame  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit counter and shift buffer; only advance on bit_en samples.
    always_ff @(posedge Clk or negedge reset) begin
        // NOTE: the shift buffer is a handful of flops, so it is cleared on
        // reset like any other state rather than left uninitialised.
        if (!reset) begin
            cnt_q    <= '0;
            buffer_q <= '0;
        end else if (bit_en) begin
            if (state_q == IDLE && !ser_in) begin
                cnt_q <= '0;
            end else if (state_q == DATA) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) buffer_q[i] <= ser_in;
                end
                if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Output holding register, handshake and one-cycle error pulses.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            overrun   <= good_frame && !hold_free;
            if (good_frame && hold_free) begin
                data_out   <= buffer_q;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
